// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared types and default geometry for the pong ball/score block
package pong_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVE   = 2'd1,
    SCORED = 2'd2
  } ball_state_t;

  localparam int DEF_H_RES     = 640;
  localparam int DEF_V_RES     = 480;
  localparam int DEF_BALL_SIZE = 8;
  localparam int DEF_PAD_W     = 8;
  localparam int DEF_PAD_H     = 48;
  localparam int DEF_PAD_L_X   = 16;
  localparam int DEF_PAD_R_X   = 616;
  localparam int DEF_SPEED     = 2;
  localparam int DEF_WIN       = 5;
  localparam int SCORE_W       = 4;

endpackage

// File: rtl/score_counter.sv
// rtl/score_counter.sv - saturating score register with clear and increment
module score_counter
  import pong_pkg::*;
#(
  parameter int MAX = DEF_WIN
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clr,
  input  logic               i_inc,
  output logic [SCORE_W-1:0] o_q
);

  logic [SCORE_W-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_q <= '0;
    end else if (i_inc && (r_q != SCORE_W'(MAX))) begin
      r_q <= r_q + SCORE_W'(1);
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/ball_score.sv
// rtl/ball_score.sv - ball motion, wall/paddle bounces, goal detection and scoring
module ball_score
  import pong_pkg::*;
#(
  parameter int H_RES     = DEF_H_RES,
  parameter int V_RES     = DEF_V_RES,
  parameter int BALL_SIZE = DEF_BALL_SIZE,
  parameter int PAD_W     = DEF_PAD_W,
  parameter int PAD_H     = DEF_PAD_H,
  parameter int PAD_L_X   = DEF_PAD_L_X,
  parameter int PAD_R_X   = DEF_PAD_R_X,
  parameter int SPEED     = DEF_SPEED,
  parameter int WIN       = DEF_WIN
) (
  input  logic               clk,
  input  logic               sim_rst,
  input  logic               frame_tick,
  input  logic               play,
  input  logic               new_game,
  input  logic [9:0]         pad_l_y,
  input  logic [9:0]         pad_r_y,
  output logic [9:0]         ball_x,
  output logic [9:0]         ball_y,
  output logic               col_esq,
  output logic               col_dir,
  output logic [SCORE_W-1:0] score_esq,
  output logic [SCORE_W-1:0] score_dir,
  output logic               win
);

  localparam logic [10:0] L_S     = 11'(SPEED);
  localparam logic [10:0] L_B     = 11'(BALL_SIZE);
  localparam logic [10:0] L_PH    = 11'(PAD_H);
  localparam logic [10:0] L_XMAX  = 11'(H_RES - BALL_SIZE);
  localparam logic [10:0] L_YMAX  = 11'(V_RES - BALL_SIZE);
  localparam logic [10:0] L_LHIT  = 11'(PAD_L_X + PAD_W);
  localparam logic [10:0] L_RX    = 11'(PAD_R_X);
  localparam logic [10:0] L_RSTOP = 11'(PAD_R_X - BALL_SIZE);
  localparam logic [9:0]  L_CX    = 10'((H_RES - BALL_SIZE) / 2);
  localparam logic [9:0]  L_CY    = 10'((V_RES - BALL_SIZE) / 2);

  // dx=1 means moving right, dy=1 means moving down
  ball_state_t r_state, w_nxt_state;
  logic [9:0]  r_x, r_y, w_nxt_x, w_nxt_y;
  logic        r_dx, r_dy, w_nxt_dx, w_nxt_dy;

  logic [10:0] w_x11, w_y11, w_pl, w_pr;
  logic        w_ovl_l, w_ovl_r;
  logic [9:0]  w_mv_x, w_mv_y;
  logic        w_mv_dx, w_mv_dy, w_goal_l, w_goal_r;
  logic        w_step, w_inc_esq, w_inc_dir;

  assign w_x11   = {1'b0, r_x};
  assign w_y11   = {1'b0, r_y};
  assign w_pl    = {1'b0, pad_l_y};
  assign w_pr    = {1'b0, pad_r_y};
  assign w_ovl_l = (w_y11 + L_B > w_pl) && (w_y11 < w_pl + L_PH);
  assign w_ovl_r = (w_y11 + L_B > w_pr) && (w_y11 < w_pr + L_PH);
  assign w_step  = (r_state == MOVE) && play && frame_tick;

  // One frame of motion; compares are rearranged so nothing subtracts below zero
  always_comb begin
    w_mv_x   = r_x;
    w_mv_y   = r_y;
    w_mv_dx  = r_dx;
    w_mv_dy  = r_dy;
    w_goal_l = 1'b0;
    w_goal_r = 1'b0;
    if (r_dy) begin
      if (w_y11 + L_S >= L_YMAX) begin
        w_mv_y  = L_YMAX[9:0];
        w_mv_dy = 1'b0;
      end else begin
        w_mv_y = 10'(w_y11 + L_S);
      end
    end else if (w_y11 <= L_S) begin
      w_mv_y  = '0;
      w_mv_dy = 1'b1;
    end else begin
      w_mv_y = 10'(w_y11 - L_S);
    end
    if (!r_dx) begin
      if ((w_x11 <= L_LHIT + L_S) && w_ovl_l) begin
        w_mv_x  = L_LHIT[9:0];
        w_mv_dx = 1'b1;
      end else if (w_x11 <= L_S) begin
        w_goal_l = 1'b1;
      end else begin
        w_mv_x = 10'(w_x11 - L_S);
      end
    end else begin
      if ((w_x11 + L_S + L_B >= L_RX) && w_ovl_r) begin
        w_mv_x  = L_RSTOP[9:0];
        w_mv_dx = 1'b0;
      end else if (w_x11 + L_S >= L_XMAX) begin
        w_goal_r = 1'b1;
      end else begin
        w_mv_x = 10'(w_x11 + L_S);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sim_rst) begin
      r_state <= IDLE;
      r_x     <= L_CX;
      r_y     <= L_CY;
      r_dx    <= 1'b1;
      r_dy    <= 1'b1;
    end else begin
      r_state <= w_nxt_state;
      r_x     <= w_nxt_x;
      r_y     <= w_nxt_y;
      r_dx    <= w_nxt_dx;
      r_dy    <= w_nxt_dy;
    end
  end

  // A goal freezes the ball where it was; dx already points at the conceding side
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_x     = r_x;
    w_nxt_y     = r_y;
    w_nxt_dx    = r_dx;
    w_nxt_dy    = r_dy;
    case (r_state)
      IDLE: begin
        if (play) w_nxt_state = MOVE;
      end
      MOVE: begin
        if (w_step) begin
          if (w_goal_l || w_goal_r) begin
            w_nxt_state = SCORED;
          end else begin
            w_nxt_x  = w_mv_x;
            w_nxt_y  = w_mv_y;
            w_nxt_dx = w_mv_dx;
            w_nxt_dy = w_mv_dy;
          end
        end
      end
      SCORED: begin
        w_nxt_state = IDLE;
        w_nxt_x     = L_CX;
        w_nxt_y     = L_CY;
      end
      default: w_nxt_state = IDLE;
    endcase
    if (new_game) begin
      w_nxt_state = IDLE;
      w_nxt_x     = L_CX;
      w_nxt_y     = L_CY;
    end
  end

  assign w_inc_dir = w_step && w_goal_l && !new_game;
  assign w_inc_esq = w_step && w_goal_r && !new_game;

  score_counter #(.MAX(WIN)) u_score_esq (
    .i_clk (clk),
    .i_rst (sim_rst),
    .i_clr (new_game),
    .i_inc (w_inc_esq),
    .o_q   (score_esq)
  );

  score_counter #(.MAX(WIN)) u_score_dir (
    .i_clk (clk),
    .i_rst (sim_rst),
    .i_clr (new_game),
    .i_inc (w_inc_dir),
    .o_q   (score_dir)
  );

  always_comb begin
    ball_x  = r_x;
    ball_y  = r_y;
    col_esq = (r_state == SCORED) && !r_dx;
    col_dir = (r_state == SCORED) && r_dx;
    win     = (score_esq == SCORE_W'(WIN)) || (score_dir == SCORE_W'(WIN));
  end

endmodule
